sys_mem_ctrl: RTL and testbench
===============================

SYS_MEM_CTRL -- requirements
Module: sys_mem_ctrl

Interface
REQ-001 Clk  input  1  system clock; all state changes on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset; clock Clk.
REQ-003 SysStrobe  input  1  request valid; sampled only in IDLE.
REQ-004 SysAddress  input  16  byte address of request.
REQ-005 SysRW  input  4  byte write enables; 4'b0000 = word read, any bit set = write of enabled bytes.
REQ-006 SysDataIn  input  32  write data; byte k on bits [8k+7:8k].
REQ-007 WaitCfg  input  2  wait-state count, sampled with request.
REQ-008 SysDataOut  output  32  read data register.
REQ-009 SysDataOE  output  1  high only in RESP of a read; requester drives shared bus when low.
REQ-010 SysReady  output  1  one-cycle completion pulse.
REQ-011 BusErr  output  1  one-cycle error pulse, coincident with SysReady.
REQ-012 ReadCount  output  16  completed non-error reads, saturating.
REQ-013 WriteCount  output  16  completed non-error writes, saturating.

Function
REQ-014 Internal storage SHALL be 4096 bytes, indexed by SysAddress[11:0].
REQ-015 States SHALL be IDLE, WAIT, ACCESS, RESP; no others reachable.
REQ-016 IDLE: SysStrobe=1 at rising edge SHALL latch SysAddress, SysRW, SysDataIn, WaitCfg and enter WAIT with counter = WaitCfg.
REQ-017 SysStrobe SHALL be ignored in WAIT, ACCESS and RESP; inputs changing after latch SHALL not affect the request.
REQ-018 WAIT: counter != 0 SHALL decrement and stay; counter == 0 SHALL go to ACCESS.
REQ-019 ACCESS (one cycle) SHALL perform the access and go to RESP.
REQ-020 RESP (one cycle) SHALL assert SysReady and return to IDLE.
REQ-021 Latency: sampling edge at cycle 0 SHALL produce SysReady high in the cycle after edge WaitCfg+2 (WaitCfg=0 -> 2 edges, WaitCfg=3 -> 5 edges).
REQ-022 Back-to-back: SysStrobe high in the first IDLE cycle after RESP SHALL start a new request at that edge.
REQ-023 Word access at address A SHALL cover bytes A, A+1, A+2, A+3, offsets added modulo 4096 (4095 wraps to 0).
REQ-024 Write: byte k written with SysDataIn[8k+7:8k] only if SysRW[k]=1; other bytes unchanged.
REQ-025 Read: SysDataOut = {byte A+3, A+2, A+1, A}, loaded in ACCESS, held until next read ACCESS or reset.
REQ-026 SysAddress[15:12] != 0 SHALL be an error: no storage write, SysDataOut loaded with 0 for reads, BusErr high in RESP, counters unchanged.
REQ-027 ReadCount/WriteCount SHALL increment by 1 in RESP of successful read/write; stay at 16'hFFFF when saturated.
REQ-028 SysDataOE SHALL be low in IDLE, WAIT, ACCESS and for write/error-free write RESP; high only in read RESP (including error reads).

Reset
REQ-029 Reset low SHALL immediately force IDLE, SysReady=0, BusErr=0, SysDataOE=0, SysDataOut=0, counter=0, ReadCount=0, WriteCount=0.
REQ-030 Reset asserted before ACCESS SHALL abort the request with no storage write; no SysReady follows.
REQ-031 Storage contents SHALL not be cleared by reset.
REQ-032 First request SHALL be sampled no earlier than the first rising edge after Reset deasserts.

Verification
REQ-033 Write A=16'h0010, SysRW=4'hF, data 32'hDEADBEEF, WaitCfg=3; then read A=16'h0010 -> SysReady 5 edges after each strobe, read SysDataOut=32'hDEADBEEF with SysDataOE=1, WriteCount=1, ReadCount=1.
REQ-034 Write 32'h11223344 SysRW=4'hF to 16'h0020, then 32'hAABBCCDD SysRW=4'b0101, then read -> 32'h11BB33DD.
REQ-035 Write 32'hCAFEF00D SysRW=4'hF at 16'h0FFE, WaitCfg=0 -> bytes 0xFFE=0D, 0xFFF=F0, 0x000=FE, 0x001=CA; read 16'h0FFE returns 32'hCAFEF00D; SysReady 2 edges after strobe.
REQ-036 Write to 16'h1000 -> SysReady and BusErr pulse together, byte 0x000 unchanged, WriteCount unchanged; read 16'hF000 -> SysDataOut=0, BusErr=1.
REQ-037 Write started with WaitCfg=3, Reset pulsed low in WAIT -> no SysReady, target bytes unchanged, all outputs at reset values; SysStrobe held high during WAIT adds no extra requests.

Source files
------------

// File: rtl/sys_mem_ctrl.sv
// Byte-addressed 4 KiB memory behind a strobe/ready request interface with
// programmable wait states, byte-lane writes, address-range error and access counters.
module sys_mem_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        SysStrobe,
  input  logic [15:0] SysAddress,
  input  logic [3:0]  SysRW,
  input  logic [31:0] SysDataIn,
  input  logic [1:0]  WaitCfg,
  output logic [31:0] SysDataOut,
  output logic        SysDataOE,
  output logic        SysReady,
  output logic        BusErr,
  output logic [15:0] ReadCount,
  output logic [15:0] WriteCount
);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e      state_q;
  logic [15:0] addr_q;
  logic [3:0]  rw_q;
  logic [31:0] data_q;
  logic [1:0]  cnt_q;

  logic [7:0]  mem [4096];
  logic [11:0] byte_addr [4];
  logic [31:0] rdata;
  logic        is_err;
  logic        is_read;
  logic        mem_we;

  assign is_err  = |addr_q[15:12];
  assign is_read = (rw_q == 4'b0000);
  assign mem_we  = (state_q == StAccess) && !is_err && !is_read;

  // Lane offsets wrap naturally in 12 bits, so 0xFFF + 1 lands on 0x000.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = addr_q[11:0] + 12'(k);
    end
  end

  assign rdata = {mem[byte_addr[3]], mem[byte_addr[2]], mem[byte_addr[1]], mem[byte_addr[0]]};

  // Storage is deliberately outside the reset domain: contents survive Reset.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (rw_q[k]) mem[byte_addr[k]] <= data_q[8*k +: 8];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rw_q       <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      SysDataOut <= '0;
      SysDataOE  <= 1'b0;
      SysReady   <= 1'b0;
      BusErr     <= 1'b0;
      ReadCount  <= '0;
      WriteCount <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (SysStrobe) begin
            addr_q  <= SysAddress;
            rw_q    <= SysRW;
            data_q  <= SysDataIn;
            cnt_q   <= WaitCfg;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            state_q <= StAccess;
          end
        end
        StAccess: begin
          state_q   <= StResp;
          SysReady  <= 1'b1;
          BusErr    <= is_err;
          SysDataOE <= is_read;
          if (is_read) begin
            SysDataOut <= is_err ? 32'h0 : rdata;
            if (!is_err && ReadCount != 16'hFFFF) ReadCount <= ReadCount + 16'd1;
          end else if (!is_err && WriteCount != 16'hFFFF) begin
            WriteCount <= WriteCount + 16'd1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          SysReady  <= 1'b0;
          BusErr    <= 1'b0;
          SysDataOE <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_mem_ctrl.sv
// Self-checking bench for sys_mem_ctrl: directed scenarios plus randomized traffic
// compared against a byte-array reference model.
module tb_sys_mem_ctrl;

  logic        Clk;
  logic        Reset;
  logic        SysStrobe;
  logic [15:0] SysAddress;
  logic [3:0]  SysRW;
  logic [31:0] SysDataIn;
  logic [1:0]  WaitCfg;
  logic [31:0] SysDataOut;
  logic        SysDataOE;
  logic        SysReady;
  logic        BusErr;
  logic [15:0] ReadCount;
  logic [15:0] WriteCount;

  int checks = 0;
  int errors = 0;

  sys_mem_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .SysStrobe  (SysStrobe),
    .SysAddress (SysAddress),
    .SysRW      (SysRW),
    .SysDataIn  (SysDataIn),
    .WaitCfg    (WaitCfg),
    .SysDataOut (SysDataOut),
    .SysDataOE  (SysDataOE),
    .SysReady   (SysReady),
    .BusErr     (BusErr),
    .ReadCount  (ReadCount),
    .WriteCount (WriteCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model
  logic [7:0]  m_mem [4096];
  int          m_rcnt;
  int          m_wcnt;
  logic [31:0] m_dout;

  function automatic logic [11:0] m_idx(input logic [15:0] a, input int k);
    return 12'((int'(a[11:0]) + k) % 4096);
  endfunction

  function automatic logic [31:0] m_word(input logic [15:0] a);
    return {m_mem[m_idx(a, 3)], m_mem[m_idx(a, 2)], m_mem[m_idx(a, 1)], m_mem[m_idx(a, 0)]};
  endfunction

  task automatic m_apply(input logic [15:0] a, input logic [3:0] rw, input logic [31:0] d);
    bit err;
    err = (a[15:12] != 4'h0);
    if (rw == 4'b0000) begin
      m_dout = err ? 32'h0 : m_word(a);
      if (!err && m_rcnt < 65535) m_rcnt++;
    end else if (!err) begin
      for (int k = 0; k < 4; k++) if (rw[k]) m_mem[m_idx(a, k)] = d[8*k +: 8];
      if (m_wcnt < 65535) m_wcnt++;
    end
  endtask

  // Drives one request and reports what was seen in the SysReady cycle.
  task automatic run_req(input logic [15:0] a, input logic [3:0] rw, input logic [31:0] d,
                         input logic [1:0] w, input bit hold, output int edges,
                         output logic [31:0] dout, output logic err, output logic oe,
                         output logic [15:0] rc, output logic [15:0] wc);
    bit got;
    @(negedge Clk);
    SysAddress = a;
    SysRW      = rw;
    SysDataIn  = d;
    WaitCfg    = w;
    SysStrobe  = 1'b1;
    @(posedge Clk);
    #1;
    if (!hold) SysStrobe = 1'b0;
    SysAddress = 16'($urandom);
    SysRW      = 4'($urandom);
    SysDataIn  = $urandom;
    WaitCfg    = 2'($urandom);
    edges = 0;
    got   = 0;
    while (!got && edges < 16) begin
      @(posedge Clk);
      edges++;
      @(negedge Clk);
      if (SysReady) got = 1;
    end
    SysStrobe = 1'b0;
    dout = SysDataOut;
    err  = BusErr;
    oe   = SysDataOE;
    rc   = ReadCount;
    wc   = WriteCount;
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    SysStrobe = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    m_rcnt = 0;
    m_wcnt = 0;
    m_dout = 32'h0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    SysStrobe = 1'b0;
    SysAddress = '0;
    SysRW = '0;
    SysDataIn = '0;
    WaitCfg = '0;
    repeat (3) @(negedge Clk);
    checks++;
    if (SysReady !== 1'b0 || BusErr !== 1'b0 || SysDataOE !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got rdy=%b err=%b oe=%b, want 0 0 0", SysReady, BusErr,
               SysDataOE);
    end
    checks++;
    if (SysDataOut !== 32'h0 || ReadCount !== 16'h0 || WriteCount !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: got dout=%h rc=%h wc=%h, want 0", SysDataOut, ReadCount,
               WriteCount);
    end
    Reset = 1'b1;
    m_rcnt = 0;
    m_wcnt = 0;
    m_dout = 32'h0;
  endtask

  // Gives every storage byte a known value, then resets to zero the counters.
  task automatic fill_memory();
    int e;
    logic [31:0] dout, d;
    logic err, oe;
    logic [15:0] rc, wc;
    for (int i = 0; i < 1024; i++) begin
      d = $urandom;
      run_req(16'(i * 4), 4'hF, d, 2'd0, 1'b0, e, dout, err, oe, rc, wc);
      m_apply(16'(i * 4), 4'hF, d);
    end
    pulse_reset();
  endtask

  task automatic test_basic_rw();
    int e;
    logic [31:0] dout;
    logic err, oe;
    logic [15:0] rc, wc;
    run_req(16'h0010, 4'hF, 32'hDEADBEEF, 2'd3, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h0010, 4'hF, 32'hDEADBEEF);
    checks++;
    if (e !== 5 || oe !== 1'b0 || wc !== 16'd1) begin
      errors++;
      $display("FAIL basic_write: got edges=%0d oe=%b wc=%0d, want 5 0 1", e, oe, wc);
    end
    run_req(16'h0010, 4'h0, 32'h0, 2'd3, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h0010, 4'h0, 32'h0);
    checks++;
    if (e !== 5 || dout !== 32'hDEADBEEF || oe !== 1'b1) begin
      errors++;
      $display("FAIL basic_read: got edges=%0d dout=%h oe=%b, want 5 deadbeef 1", e, dout, oe);
    end
    checks++;
    if (rc !== 16'd1 || wc !== 16'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_counts: got rc=%0d wc=%0d err=%b, want 1 1 0", rc, wc, err);
    end
  endtask

  task automatic test_byte_enables();
    int e;
    logic [31:0] dout;
    logic err, oe;
    logic [15:0] rc, wc;
    run_req(16'h0020, 4'hF, 32'h11223344, 2'd1, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h0020, 4'hF, 32'h11223344);
    run_req(16'h0020, 4'b0101, 32'hAABBCCDD, 2'd2, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h0020, 4'b0101, 32'hAABBCCDD);
    run_req(16'h0020, 4'h0, 32'h0, 2'd0, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h0020, 4'h0, 32'h0);
    checks++;
    if (dout !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL byte_enables: got %h, want 11bb33dd", dout);
    end
  endtask

  task automatic test_wrap();
    int e;
    logic [31:0] dout;
    logic err, oe;
    logic [15:0] rc, wc;
    run_req(16'h0FFE, 4'hF, 32'hCAFEF00D, 2'd0, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h0FFE, 4'hF, 32'hCAFEF00D);
    checks++;
    if (e !== 2) begin
      errors++;
      $display("FAIL wrap_latency: got %0d edges, want 2", e);
    end
    run_req(16'h0FFE, 4'h0, 32'h0, 2'd0, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h0FFE, 4'h0, 32'h0);
    checks++;
    if (dout !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL wrap_read: got %h, want cafef00d", dout);
    end
    run_req(16'h0000, 4'h0, 32'h0, 2'd0, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h0000, 4'h0, 32'h0);
    checks++;
    if (dout[15:0] !== 16'hCAFE || dout !== m_dout) begin
      errors++;
      $display("FAIL wrap_low_bytes: got %h, want %h", dout, m_dout);
    end
  endtask

  task automatic test_bus_err();
    int e;
    logic [31:0] dout;
    logic err, oe;
    logic [15:0] rc, wc;
    run_req(16'h1000, 4'hF, 32'h55667788, 2'd1, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h1000, 4'hF, 32'h55667788);
    checks++;
    if (e !== 3 || err !== 1'b1 || wc !== 16'(m_wcnt)) begin
      errors++;
      $display("FAIL err_write: got edges=%0d err=%b wc=%0d, want 3 1 %0d", e, err, wc, m_wcnt);
    end
    run_req(16'h0000, 4'h0, 32'h0, 2'd0, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h0000, 4'h0, 32'h0);
    checks++;
    if (dout !== m_dout || err !== 1'b0) begin
      errors++;
      $display("FAIL err_no_write: got %h err=%b, want %h 0", dout, err, m_dout);
    end
    run_req(16'hF000, 4'h0, 32'h0, 2'd2, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'hF000, 4'h0, 32'h0);
    checks++;
    if (dout !== 32'h0 || err !== 1'b1 || oe !== 1'b1 || rc !== 16'(m_rcnt)) begin
      errors++;
      $display("FAIL err_read: got dout=%h err=%b oe=%b rc=%0d, want 0 1 1 %0d", dout, err, oe,
               rc, m_rcnt);
    end
  endtask

  task automatic test_reset_abort();
    int e;
    int pulses;
    logic [31:0] dout;
    logic err, oe;
    logic [15:0] rc, wc;
    @(negedge Clk);
    SysAddress = 16'h0050;
    SysRW      = 4'hF;
    SysDataIn  = 32'h0BADF00D;
    WaitCfg    = 2'd3;
    SysStrobe  = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++;
    if (SysReady !== 1'b0 || BusErr !== 1'b0 || SysDataOE !== 1'b0 || SysDataOut !== 32'h0 ||
        ReadCount !== 16'h0 || WriteCount !== 16'h0) begin
      errors++;
      $display("FAIL abort_outputs: got rdy=%b err=%b oe=%b dout=%h rc=%0d wc=%0d, want zeros",
               SysReady, BusErr, SysDataOE, SysDataOut, ReadCount, WriteCount);
    end
    SysStrobe = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    m_rcnt = 0;
    m_wcnt = 0;
    pulses = 0;
    repeat (8) begin
      @(negedge Clk);
      if (SysReady) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_ready: got %0d ready pulses, want 0", pulses);
    end
    run_req(16'h0050, 4'h0, 32'h0, 2'd0, 1'b0, e, dout, err, oe, rc, wc);
    m_apply(16'h0050, 4'h0, 32'h0);
    checks++;
    if (dout !== m_dout) begin
      errors++;
      $display("FAIL abort_no_write: got %h, want %h", dout, m_dout);
    end
  endtask

  task automatic test_strobe_hold();
    int e;
    int pulses;
    logic [31:0] dout;
    logic err, oe;
    logic [15:0] rc, wc;
    run_req(16'h0100, 4'hF, 32'h01020304, 2'd3, 1'b1, e, dout, err, oe, rc, wc);
    m_apply(16'h0100, 4'hF, 32'h01020304);
    pulses = 0;
    repeat (8) begin
      @(negedge Clk);
      if (SysReady) pulses++;
    end
    checks++;
    if (e !== 5 || pulses !== 0 || WriteCount !== 16'(m_wcnt)) begin
      errors++;
      $display("FAIL strobe_hold: got edges=%0d extra=%0d wc=%0d, want 5 0 %0d", e, pulses,
               WriteCount, m_wcnt);
    end
  endtask

  task automatic test_random();
    int e;
    int bad;
    logic [31:0] dout, d;
    logic err, oe;
    logic [15:0] rc, wc, a;
    logic [3:0] rw;
    logic [1:0] w;
    bit exp_err;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      a  = {($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, 12'($urandom)};
      rw = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
      d  = $urandom;
      w  = 2'($urandom);
      run_req(a, rw, d, w, 1'b0, e, dout, err, oe, rc, wc);
      m_apply(a, rw, d);
      exp_err = (a[15:12] != 4'h0);
      checks++;
      if (e !== int'(w) + 2 || err !== exp_err || oe !== (rw == 4'h0) || dout !== m_dout ||
          rc !== 16'(m_rcnt) || wc !== 16'(m_wcnt)) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random_%0d: got e=%0d err=%b oe=%b dout=%h rc=%0d wc=%0d, want e=%0d err=%b oe=%b dout=%h rc=%0d wc=%0d",
                   i, e, err, oe, dout, rc, wc, int'(w) + 2, exp_err, (rw == 4'h0), m_dout,
                   m_rcnt, m_wcnt);
      end
    end
  endtask

  initial begin
    test_reset();
    fill_memory();
    test_basic_rw();
    test_byte_enables();
    test_wrap();
    test_bus_err();
    test_reset_abort();
    test_strobe_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
